// File: rtl/freq_gate_seq.sv
// Gate sequencer and auto-ranger for the BCD frequency meter: clear -> gate -> settle -> hold, repeating.
// Outputs are registered and change on the edge that enters each state. There is no backpressure; timing comes from the tick counter only.
module freq_gate_seq #(
   parameter int unsigned GATE_TICKS = 50_000_000,
   parameter int unsigned CLR_TICKS  = 2,
   parameter int unsigned DISP_TICKS = 25_000_000,
   parameter int unsigned RANGE_MAX  = 3
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       start_en,
   input  logic       auto_en,
   input  logic [1:0] man_range,
   input  logic       cnt_ovf,
   input  logic [3:0] cnt_msd,
   output logic       count_clear,
   output logic       count_ena,
   output logic       lock,
   output logic [1:0] range_sel,
   output logic       overrange,
   output logic       meas_valid
);

   localparam int unsigned MAX_GC    = (GATE_TICKS > CLR_TICKS) ? GATE_TICKS : CLR_TICKS;
   localparam int unsigned MAX_TICKS = (MAX_GC > DISP_TICKS) ? MAX_GC : DISP_TICKS;
   localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

   localparam logic [TW-1:0] CLR_LD  = TW'(CLR_TICKS - 1);
   localparam logic [TW-1:0] GATE_LD = TW'(GATE_TICKS - 1);
   localparam logic [TW-1:0] DISP_LD = TW'(DISP_TICKS - 1);
   localparam logic [1:0]    RMAX    = 2'(RANGE_MAX);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_GATE   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          ovf_sticky_q, ovf_sticky_d;
   logic [1:0]    range_q, range_d;
   logic          overrange_q, overrange_d;
   logic          meas_valid_q, meas_valid_d;
   logic          clear_q, clear_d;
   logic          ena_q, ena_d;
   logic          lock_q, lock_d;
   logic          ovf_now;

   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      ovf_sticky_d = ovf_sticky_q;
      range_d      = range_q;
      overrange_d  = overrange_q;
      meas_valid_d = 1'b0;
      ovf_now      = ovf_sticky_q | cnt_ovf;

      case (state_q)
         S_IDLE: begin
            if (start_en) begin
               state_d = S_CLEAR;
               tick_d  = CLR_LD;
            end
         end
         S_CLEAR: begin
            ovf_sticky_d = 1'b0;
            if (tick_q == '0) begin
               state_d = S_GATE;
               tick_d  = GATE_LD;
            end else begin
               tick_d = tick_q - 1'b1;
            end
         end
         S_GATE: begin
            ovf_sticky_d = ovf_now;
            if (tick_q == '0) begin
               state_d = S_SETTLE;
               tick_d  = '0;
            end else begin
               tick_d = tick_q - 1'b1;
            end
         end
         S_SETTLE: begin
            ovf_sticky_d = ovf_now;
            state_d      = S_HOLD;
            tick_d       = DISP_LD;
            meas_valid_d = 1'b1;
            // The range picked here applies to the next gate; the held result stays on the old range.
            if (auto_en) begin
               overrange_d = 1'b0;
               if (ovf_now) begin
                  if (range_q < RMAX) range_d = range_q + 2'd1;
                  else                overrange_d = 1'b1;
               end else if ((cnt_msd == 4'd0) && (range_q != 2'd0)) begin
                  range_d = range_q - 2'd1;
               end
            end else begin
               overrange_d = ovf_now;
            end
         end
         S_HOLD: begin
            if (tick_q == '0) begin
               state_d = start_en ? S_CLEAR : S_IDLE;
               tick_d  = start_en ? CLR_LD : '0;
            end else begin
               tick_d = tick_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tick_d  = '0;
         end
      endcase

      if (!auto_en && ((state_q == S_IDLE) || (state_q == S_CLEAR))) range_d = man_range;

      clear_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
      ena_d   = (state_d == S_GATE);
      lock_d  = (state_d == S_HOLD);
   end

   always_ff @(posedge sysclk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         tick_q       <= '0;
         ovf_sticky_q <= 1'b0;
         range_q      <= 2'd0;
         overrange_q  <= 1'b0;
         meas_valid_q <= 1'b0;
         clear_q      <= 1'b1;
         ena_q        <= 1'b0;
         lock_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         ovf_sticky_q <= ovf_sticky_d;
         range_q      <= range_d;
         overrange_q  <= overrange_d;
         meas_valid_q <= meas_valid_d;
         clear_q      <= clear_d;
         ena_q        <= ena_d;
         lock_q       <= lock_d;
      end
   end

   assign count_clear = clear_q;
   assign count_ena   = ena_q;
   assign lock        = lock_q;
   assign range_sel   = range_q;
   assign overrange   = overrange_q;
   assign meas_valid  = meas_valid_q;

endmodule

// File: tb/tb_freq_gate_seq.sv
// Bench for freq_gate_seq with short gate/display timing; each measurement's expected profile is queued
// at gate start and compared by a monitor when the display lock drops.
module tb_freq_gate_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_en = 1'b0;
   logic       auto_en = 1'b0;
   logic [1:0] man_range = 2'd0;
   logic       cnt_ovf = 1'b0;
   logic [3:0] cnt_msd = 4'd5;
   logic       count_clear, count_ena, lock, overrange, meas_valid;
   logic [1:0] range_sel;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int clr;
      int gate_rng;
      int rng_after;
      int ovr;
   } exp_t;

   exp_t sb[$];

   freq_gate_seq #(.GATE_TICKS(10), .CLR_TICKS(2), .DISP_TICKS(5), .RANGE_MAX(3)) dut (
      .sysclk(clk), .rst(rst), .start_en(start_en), .auto_en(auto_en), .man_range(man_range),
      .cnt_ovf(cnt_ovf), .cnt_msd(cnt_msd), .count_clear(count_clear), .count_ena(count_ena),
      .lock(lock), .range_sel(range_sel), .overrange(overrange), .meas_valid(meas_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: measures each cycle's clear/gate/settle/hold profile and checks it against the queue.
   int clr_c, ena_c, set_c, lock_c, mv_c, g_clr, g_rng, a_rng, a_ovr;
   logic prev_clear, prev_lock;
   initial begin
      exp_t e;
      clr_c = 0; ena_c = 0; set_c = 0; lock_c = 0; mv_c = 0;
      g_clr = 0; g_rng = 0; a_rng = 0; a_ovr = 0;
      prev_clear = 1'b0; prev_lock = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            clr_c = 0; ena_c = 0; set_c = 0; lock_c = 0; mv_c = 0;
            prev_clear = 1'b0; prev_lock = 1'b0;
         end else begin
            if (count_clear) begin
               if (!prev_clear) clr_c = 0;
               clr_c++;
            end
            if (count_ena) begin
               if (ena_c == 0) begin
                  g_clr = clr_c;
                  g_rng = int'(range_sel);
               end
               ena_c++;
            end
            if (!count_clear && !count_ena && !lock) set_c++;
            if (lock) begin
               lock_c++;
               if (meas_valid) begin
                  mv_c++;
                  a_rng = int'(range_sel);
                  a_ovr = int'(overrange);
               end
            end else if (meas_valid) begin
               chk("meas_valid_outside_hold", 1, 0);
            end
            if (prev_lock && !lock) begin
               if (sb.size() == 0) begin
                  chk("unexpected_measurement", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("clear_cycles", g_clr, e.clr);
                  chk("gate_cycles", ena_c, 10);
                  chk("settle_cycles", set_c, 1);
                  chk("lock_cycles", lock_c, 5);
                  chk("meas_valid_pulses", mv_c, 1);
                  chk("range_during_gate", g_rng, e.gate_rng);
                  chk("range_after_decision", a_rng, e.rng_after);
                  chk("overrange", a_ovr, e.ovr);
               end
               ena_c = 0; set_c = 0; lock_c = 0; mv_c = 0;
            end
            prev_clear = count_clear;
            prev_lock  = lock;
         end
      end
   end

   // Wait for the next gate start, queue its expectation, drive cnt_msd and an optional mid-gate ovf pulse.
   task automatic measure(input int clr, input int grng, input int arng, input int ovr,
                          input bit do_ovf, input logic [3:0] msd);
      int n;
      exp_t e;
      n = 0;
      while (count_ena && n < 200) begin @(negedge clk); n++; end
      while (!count_ena && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         chk("timeout_gate_start", n, 0);
      end else begin
         e.clr = clr; e.gate_rng = grng; e.rng_after = arng; e.ovr = ovr;
         sb.push_back(e);
         cnt_msd = msd;
         repeat (4) @(negedge clk);
         cnt_ovf = do_ovf;
         @(negedge clk);
         cnt_ovf = 1'b0;
      end
   endtask

   initial begin
      int n;
      start_en = 1'b1; auto_en = 1'b0; man_range = 2'd1;
      repeat (2) @(negedge clk);
      chk("reset_clear", int'(count_clear), 1);
      chk("reset_ena", int'(count_ena), 0);
      chk("reset_lock", int'(lock), 0);
      chk("reset_range", int'(range_sel), 0);
      chk("reset_overrange", int'(overrange), 0);
      chk("reset_meas_valid", int'(meas_valid), 0);
      @(posedge clk); #1 rst = 1'b1;

      // Manual range 1; the change to 0 during the second gate only lands at the next clear.
      measure(3, 1, 1, 0, 1'b0, 4'd5);
      measure(2, 1, 1, 0, 1'b0, 4'd5);
      man_range = 2'd0;
      measure(2, 0, 1, 0, 1'b1, 4'd5);
      auto_en = 1'b1;
      measure(2, 1, 2, 0, 1'b1, 4'd5);
      measure(2, 2, 3, 0, 1'b1, 4'd5);
      measure(2, 3, 3, 1, 1'b1, 4'd5);
      measure(2, 3, 3, 0, 1'b0, 4'd5);
      measure(2, 3, 2, 0, 1'b0, 4'd0);
      measure(2, 2, 1, 0, 1'b0, 4'd0);
      measure(2, 1, 2, 0, 1'b1, 4'd5);
      measure(2, 2, 2, 0, 1'b0, 4'd4);
      start_en = 1'b0;

      n = 0;
      while (!lock && n < 100) begin @(negedge clk); n++; end
      while (lock && n < 100) begin @(negedge clk); n++; end
      chk("stop_timeout", int'(n >= 100), 0);
      chk("stop_idle_clear", int'(count_clear), 1);
      chk("stop_idle_ena", int'(count_ena), 0);
      repeat (3) @(negedge clk);
      chk("stop_idle_stays", int'(count_ena), 0);
      chk("stop_range_kept", int'(range_sel), 2);

      // Reset on the 5th gate cycle discards the measurement.
      start_en = 1'b1;
      n = 0;
      while (!count_ena && n < 100) begin @(negedge clk); n++; end
      chk("restart_timeout", int'(n >= 100), 0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midgate_rst_clear", int'(count_clear), 1);
      chk("midgate_rst_ena", int'(count_ena), 0);
      chk("midgate_rst_lock", int'(lock), 0);
      chk("midgate_rst_range", int'(range_sel), 0);
      chk("midgate_rst_meas_valid", int'(meas_valid), 0);
      start_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_no_meas_valid", int'(meas_valid), 0);
      chk("post_rst_idle", int'(count_clear), 1);
      chk("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
